// File: rtl/guia05_pkg.sv
// Shared definitions for the Guia 05 truth-table sweep: FSM state encoding
// and the expected tables of the individual exercises.
package guia05_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    // Guia_0503: s = ~(~a | b) = a & ~b, a = stim[1], b = stim[0]
    localparam int         GUIA0503_N_IN   = 2;
    localparam logic [3:0] GUIA0503_EXPECT = 4'b0100;

    function automatic int table_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/guia05_settle_timer.sv
// Load/count-down timer: after a load, expired is high on the SETTLE-th
// enabled cycle, telling the sweep FSM the gate output may be sampled.
module guia05_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CW'(SETTLE - 1);
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign expired = en && (count_q == '0);

endmodule

// File: rtl/guia05_truth_sweep.sv
// Drives every input combination of a combinational gate in ascending order,
// captures the gate output into a truth table and compares it with EXPECT.
module guia05_truth_sweep
    import guia05_pkg::*;
#(
    parameter int                          N_IN   = GUIA0503_N_IN,
    parameter int                          SETTLE = 1,
    parameter logic [(1 << N_IN)-1:0]      EXPECT = GUIA0503_EXPECT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic [N_IN-1:0]                stim,
    input  logic                           dut_s,
    output logic                           busy,
    output logic                           done,
    output logic [(1 << N_IN)-1:0]         table_o,
    output logic                           table_valid,
    output logic                           mismatch,
    output logic [N_IN:0]                  err_count
);

    localparam int              TW   = table_width(N_IN);
    localparam logic [N_IN-1:0] LAST = '1;

    sweep_state_t    state_q;
    logic [N_IN-1:0] stim_q;
    logic            busy_q;
    logic            done_q;
    logic            valid_q;
    logic [TW-1:0]   table_q;
    logic [N_IN:0]   err_q;

    logic timer_load;
    logic timer_en;
    logic timer_expired;

    // Reload on every entry into SETTLE: from IDLE on start, from SAMPLE unless last vector
    assign timer_load = ((state_q == ST_IDLE) && start) ||
                        ((state_q == ST_SAMPLE) && (stim_q != LAST));
    assign timer_en   = (state_q == ST_SETTLE);

    guia05_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            table_q <= '0;
            err_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_SETTLE;
                        stim_q  <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        table_q <= '0;
                        err_q   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (timer_expired) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    table_q[stim_q] <= dut_s;
                    if (dut_s != EXPECT[stim_q]) begin
                        err_q <= err_q + (N_IN + 1)'(1);
                    end
                    if (stim_q == LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end else begin
                        stim_q  <= stim_q + N_IN'(1);
                        state_q <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stim        = stim_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign table_o     = table_q;
    assign table_valid = valid_q;
    assign err_count   = err_q;
    assign mismatch    = (err_q != '0);

endmodule
